// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot loader on the write side of the instruction memory. It accepts a byte
// stream over a valid/ready handshake and packs four bytes into one 32-bit
// instruction word. The first byte becomes the MSB. Words are written into imem
// from word address 0 upward. The processor is held in reset until a complete
// program has been loaded without error.
//
// Ports:
//   clock       system clock; all logic on the rising edge
//   reset       synchronous, active-high reset
//   start       single-cycle pulse that begins a load session
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_last     final byte of the program (qualified by in_valid)
//   in_ready    byte-stream ready; high only while loading
//   wren_imem   imem write enable, one-cycle pulse per word
//   waddr_imem  imem write word address
//   d_imem      imem write data
//   proc_reset  processor reset; 1 holds the core in reset
//   word_count  words written in the current or last session
//   load_error  sticky error flag for the current session
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WORDS  = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  wren_imem,
    output logic [ADDR_WIDTH-1:0] waddr_imem,
    output logic [31:0]           d_imem,
    output logic                  proc_reset,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  load_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

    state_e                state_q,      state_d;
    logic [1:0]            byte_idx_q,   byte_idx_d;
    // Only bytes 0..2 are held here; byte 3 goes straight into the write data.
    logic [23:0]           asm_q,        asm_d;
    logic                  wren_q,       wren_d;
    logic [ADDR_WIDTH-1:0] waddr_q,      waddr_d;
    logic [31:0]           data_q,       data_d;
    logic [ADDR_WIDTH:0]   count_q,      count_d;
    logic                  error_q,      error_d;
    logic                  proc_reset_q, proc_reset_d;
    logic                  accept;

    // NOTE: every signal written in this block gets a default first, so no path
    // through the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wren_d     = 1'b0;
        waddr_d    = waddr_q;
        data_d     = data_q;
        count_d    = count_q;
        error_d    = error_q;
        accept     = in_valid && (state_q == S_LOAD);

        unique case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    byte_idx_d = 2'd0;
                    count_d    = '0;
                    error_d    = 1'b0;
                end
            end
            S_LOAD: begin
                // A start pulse is ignored here, so a session cannot restart
                // part of the way through a word.
                if (accept) begin
                    if (count_q == MAX_COUNT) begin
                        // Memory is full, so any further byte is an overflow.
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else if (byte_idx_q == 2'd3) begin
                        wren_d     = 1'b1;
                        waddr_d    = count_q[ADDR_WIDTH-1:0];
                        data_d     = {asm_q, in_data};
                        count_d    = count_q + ONE_WORD;
                        byte_idx_d = 2'd0;
                        if (in_last) begin
                            state_d = S_RUN;
                        end
                    end else if (in_last) begin
                        // Program length is not a multiple of four bytes.
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        case (byte_idx_q)
                            2'd0:    asm_d[23:16] = in_data;
                            2'd1:    asm_d[15:8]  = in_data;
                            default: asm_d[7:0]   = in_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The core is released only after RUN has lasted one full cycle. This
        // places the release one cycle after the final write pulse. A start
        // pulse in RUN raises the reset again on the very next cycle.
        proc_reset_d = !((state_q == S_RUN) && (state_d == S_RUN));
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            asm_q        <= '0;
            wren_q       <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
            proc_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            wren_q       <= wren_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            count_q      <= count_d;
            error_q      <= error_d;
            proc_reset_q <= proc_reset_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign wren_imem  = wren_q;
    assign waddr_imem = waddr_q;
    assign d_imem     = data_q;
    assign proc_reset = proc_reset_q;
    assign word_count = count_q;
    assign load_error = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. The stimulus pushes each expected imem
// write into a queue. A monitor pops and compares that queue on every write
// pulse. Status outputs are compared directly at fixed points in the stimulus.
// The DUT uses MAX_WORDS=4 so that the overflow boundary is reachable.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          wren_imem;
    logic [AW-1:0] waddr_imem;
    logic [31:0]   d_imem;
    logic          proc_reset;
    logic [AW:0]   word_count;
    logic          load_error;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t exp_q[$];

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wren_imem  (wren_imem),
        .waddr_imem (waddr_imem),
        .d_imem     (d_imem),
        .proc_reset (proc_reset),
        .word_count (word_count),
        .load_error (load_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (wren_imem === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%08h, expected no write",
                         waddr_imem, d_imem);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (waddr_imem !== e.addr || d_imem !== e.data) begin
                    n_errors++;
                    $display("FAIL write: got addr=0x%0h data=0x%08h, expected addr=0x%0h data=0x%08h",
                             waddr_imem, d_imem, e.addr, e.data);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Present one byte and return just after the edge on which it is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        tick();
        tick();
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_wren",       32'(wren_imem),  32'd0);
        check("rst_proc_reset", 32'(proc_reset), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_proc_reset", 32'(proc_reset), 32'd1);

        // Test 1: one word, one byte per cycle.
        pulse_start();
        check("t1_in_ready", 32'(in_ready), 32'd1);
        expect_write(12'd0, 32'h12345678);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        check("t1_wren_pulse",      32'(wren_imem),  32'd1);
        check("t1_word_count",      32'(word_count), 32'd1);
        check("t1_proc_reset_hold", 32'(proc_reset), 32'd1);
        check("t1_load_error",      32'(load_error), 32'd0);
        tick();
        check("t1_wren_low",        32'(wren_imem),  32'd0);
        check("t1_proc_released",   32'(proc_reset), 32'd0);
        check("t1_in_ready_run",    32'(in_ready),   32'd0);
        check("t1_waddr_hold",      32'(waddr_imem), 32'd0);
        check("t1_data_hold",       d_imem,          32'h12345678);

        // Test 2: three words with in_valid toggling every cycle.
        pulse_start();
        check("t2_proc_reset", 32'(proc_reset), 32'd1);
        expect_write(12'd0, 32'h00010203);
        expect_write(12'd1, 32'h04050607);
        expect_write(12'd2, 32'h08090A0B);
        for (int i = 0; i < 12; i++) begin
            b = 8'(i);
            send_byte(b, i == 11);
            if (i != 11) tick();
        end
        check("t2_word_count", 32'(word_count), 32'd3);
        tick();
        check("t2_proc_released", 32'(proc_reset), 32'd0);
        check("t2_in_ready",      32'(in_ready),   32'd0);

        // Test 3: program ends on a partial word.
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        check("t3_load_error",  32'(load_error), 32'd1);
        check("t3_in_ready",    32'(in_ready),   32'd0);
        check("t3_word_count",  32'(word_count), 32'd0);
        tick();
        tick();
        check("t3_proc_reset",  32'(proc_reset), 32'd1);
        pulse_start();
        check("t3_error_clear", 32'(load_error), 32'd0);
        check("t3_reload_rdy",  32'(in_ready),   32'd1);

        // Test 4: fill all four words, then overflow with one more byte.
        for (int w = 0; w < 4; w++) begin
            expect_write(AW'(w), {8'(8'hA0 + 4*w), 8'(8'hA1 + 4*w),
                                  8'(8'hA2 + 4*w), 8'(8'hA3 + 4*w)});
        end
        for (int i = 0; i < 16; i++) begin
            b = 8'(8'hA0 + i);
            send_byte(b, 1'b0);
        end
        check("t4_word_count_full", 32'(word_count), 32'd4);
        check("t4_no_error_yet",    32'(load_error), 32'd0);
        send_byte(8'hFF, 1'b0);
        check("t4_overflow_error",  32'(load_error), 32'd1);
        check("t4_in_ready",        32'(in_ready),   32'd0);
        tick();
        check("t4_word_count_end",  32'(word_count), 32'd4);
        check("t4_proc_reset",      32'(proc_reset), 32'd1);

        // Test 5: reset in the middle of the second word.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start();
        expect_write(12'd0, 32'h01020304);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_in_ready",   32'(in_ready),   32'd0);
        check("t5_wren",       32'(wren_imem),  32'd0);
        check("t5_waddr",      32'(waddr_imem), 32'd0);
        check("t5_data",       d_imem,          32'd0);
        check("t5_proc_reset", 32'(proc_reset), 32'd1);
        check("t5_word_count", 32'(word_count), 32'd0);
        check("t5_load_error", 32'(load_error), 32'd0);
        tick();
        tick();
        pulse_start();
        expect_write(12'd0, 32'h11223344);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        check("t5_reload_count", 32'(word_count), 32'd1);
        tick();
        check("t5_released", 32'(proc_reset), 32'd0);

        // Test 6: restart from RUN, with a stray start pulse during LOAD.
        pulse_start();
        check("t6_proc_reset_up", 32'(proc_reset), 32'd1);
        check("t6_count_clear",   32'(word_count), 32'd0);
        expect_write(12'd0, 32'hDEADBEEF);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        pulse_start();
        check("t6_still_loading", 32'(in_ready), 32'd1);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b1);
        check("t6_word_count", 32'(word_count), 32'd1);
        check("t6_wren",       32'(wren_imem),  32'd1);
        tick();
        check("t6_released",   32'(proc_reset), 32'd0);

        tick();
        tick();
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot loader on the write side of the instruction memory. The processor only reads imem through address_imem and q_imem; this block is the writer. It accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words. It writes those words into imem from address 0 upward and holds the processor in reset until the program is fully and correctly loaded.

Parameters:
ADDR_WIDTH, 12, imem word-address width; matches address_imem.
MAX_WORDS, 4096, capacity in words; must be no greater than 2**ADDR_WIDTH.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse that begins a load session.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_last  input  1  marks the final byte of the program; qualified by in_valid.
in_ready  output  1  byte-stream ready.
wren_imem  output  1  imem write enable, one-cycle pulse per word.
waddr_imem  output  ADDR_WIDTH  imem write word address.
d_imem  output  32  imem write data.
proc_reset  output  1  reset to the processor; 1 holds the core in reset.
word_count  output  ADDR_WIDTH+1  words written in the current or last session.
load_error  output  1  sticky error flag for the current session.

Behaviour:
- Reset values: state IDLE, in_ready 0, wren_imem 0, waddr_imem 0, d_imem 0, proc_reset 1, word_count 0, load_error 0, byte index 0.
- Reset is honoured in every state. A mid-load reset discards any partial word, issues no write, and returns to IDLE.
- A byte is accepted only on a cycle where in_valid=1 and in_ready=1. in_ready is combinational from state: it is 1 only in LOAD. Throughput is one byte per cycle.
- States:
  - IDLE:
    - proc_reset 1.
    - start=1 -> LOAD; word_count, byte index, and load_error cleared.
  - LOAD:
    - proc_reset 1.
    - Accepted byte k (k = 0..3) goes to bits [31-8k : 24-8k] of an assembly register; byte 0 is the MSB.
    - On acceptance of byte 3, the next cycle has wren_imem=1, waddr_imem=word_count, and d_imem equal to the assembled word. word_count increments in that same cycle. The byte index wraps to 0.
    - start is ignored in LOAD.
    - in_last accepted with byte index 3: the word is written as above, then the FSM moves to RUN.
    - in_last accepted with byte index 0..2: the partial word is dropped, no write occurs, load_error is set to 1, and the FSM moves to ERROR.
    - Overflow: a byte accepted while word_count == MAX_WORDS is dropped. load_error is set to 1 and the FSM moves to ERROR.
  - RUN:
    - proc_reset falls to 0 in the cycle after the final write pulse.
    - in_ready 0.
    - start=1 -> LOAD; proc_reset returns to 1 in the next cycle. word_count and load_error are cleared.
  - ERROR:
    - proc_reset stays 1.
    - in_ready 0.
    - start=1 -> LOAD with counters and the flag cleared.
- wren_imem is never high for two consecutive cycles unless consecutive words complete on consecutive byte-3 acceptances.
- waddr_imem and d_imem hold their last written values while wren_imem=0.
- A zero-length program cannot occur: in_last always accompanies a byte.
- Words are contiguous from address 0. The block performs no reads and has no imem read path.

Test Plan:
1. Reset, then start. Stream bytes 0x12,0x34,0x56,0x78 (last on 0x78) at one per cycle -> one wren_imem pulse the cycle after 0x78, with waddr_imem=0 and d_imem=0x12345678. word_count=1, load_error=0. proc_reset falls to 0 one cycle after the pulse.
2. Start, then stream 12 bytes 0x00..0x0B with in_valid toggling 1/0 every cycle (last on 0x0B) -> exactly three writes: addr 0 = 0x00010203, addr 1 = 0x04050607, addr 2 = 0x08090A0B. word_count=3, then RUN.
3. Start, then stream 0xAA,0xBB,0xCC with in_last on 0xCC -> no write, load_error=1, proc_reset stays 1, in_ready=0. A subsequent start clears load_error to 0.
4. With MAX_WORDS=4, stream 16 bytes without in_last, then one more byte -> four writes to addresses 0..3. The 17th byte sets load_error=1 and enters ERROR; no write to address 4.
5. Mid-load reset after 2 bytes of word 1 (word 0 already written) -> no further wren_imem. All outputs return to reset values. A new load then starts writing at address 0.
6. In RUN, pulse start, then load 4 bytes 0xDEADBEEF -> proc_reset=1 the cycle after start. addr 0 is rewritten with 0xDEADBEEF, word_count=1, and proc_reset is released again. A start pulse during LOAD causes no state change.
